// File: rtl/sipo_deserializer_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// Optional parity build: SIPO_DESERIALIZER_PARITY_EN.
package sipo_pkg;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } bit_order_e;

    // Counter must hold 0..DATA_WIDTH (the parity build uses the top value).
    function automatic int unsigned cnt_width(input int unsigned data_width);
        return $clog2(data_width + 1);
    endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input / parallel output bundle of the deserializer.
// SIPO_DESERIALIZER_PARITY_EN adds the parity_err signal.
interface sipo_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    import sipo_pkg::*;

    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

    logic                  din;
    logic                  din_valid;
    logic                  flush;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_valid;
    logic                  dout_ready;
    logic [CNT_W-1:0]      bit_cnt;
    logic                  overflow;
`ifdef SIPO_DESERIALIZER_PARITY_EN
    logic                  parity_err;

    modport master (
        output din, din_valid, flush, dout_ready,
        input  shift_q, dout, dout_valid, bit_cnt, overflow, parity_err
    );
    modport slave (
        input  din, din_valid, flush, dout_ready,
        output shift_q, dout, dout_valid, bit_cnt, overflow, parity_err
    );
`else
    modport master (
        output din, din_valid, flush, dout_ready,
        input  shift_q, dout, dout_valid, bit_cnt, overflow
    );
    modport slave (
        input  din, din_valid, flush, dout_ready,
        output shift_q, dout, dout_valid, bit_cnt, overflow
    );
`endif

endinterface

// File: rtl/sipo_deserializer_out_reg.sv
// Single-entry valid/ready output register with sticky overflow on dropped words.
// SIPO_DESERIALIZER_PARITY_EN adds a parity_err flag loaded alongside dout.
module sipo_out_reg #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
`ifdef SIPO_DESERIALIZER_PARITY_EN
    input  logic                  load_perr,
    output logic                  parity_err,
`endif
    input  logic                  ready,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  overflow
);

    logic space_c;

    // A slot is free if empty or being drained this cycle.
    assign space_c = ~dout_valid | ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
`ifdef SIPO_DESERIALIZER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (load && space_c) begin
            dout       <= load_data;
            dout_valid <= 1'b1;
`ifdef SIPO_DESERIALIZER_PARITY_EN
            parity_err <= load_perr;
`endif
        end else if (load) begin
            overflow   <= 1'b1;
        end else if (dout_valid && ready) begin
            dout_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: shift register, bit counter, output slot.
// SIPO_DESERIALIZER_PARITY_EN appends one even-parity bit per word.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LSB_FIRST  = 0
) (
    input logic   clk,
    input logic   resetn,
    sipo_if.slave bus
);

    localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);
    localparam bit_order_e  ORDER = (LSB_FIRST != 0) ? sipo_pkg::LSB_FIRST : MSB_FIRST;
`ifdef SIPO_DESERIALIZER_PARITY_EN
    localparam int unsigned LAST_CNT = DATA_WIDTH;
`else
    localparam int unsigned LAST_CNT = DATA_WIDTH - 1;
`endif

    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      bit_cnt;
    logic [DATA_WIDTH-1:0] shift_next_c;
    logic [DATA_WIDTH-1:0] word_c;
    logic [DATA_WIDTH-1:0] word_ord_c;
    logic                  accept_c;
    logic                  last_c;
    logic                  complete_c;
    logic                  shift_en_c;

    assign accept_c     = bus.din_valid & ~bus.flush;
    assign last_c       = (bit_cnt == CNT_W'(LAST_CNT));
    assign complete_c   = accept_c & last_c;
    assign shift_next_c = {shift_q[DATA_WIDTH-2:0], bus.din};

`ifdef SIPO_DESERIALIZER_PARITY_EN
    logic perr_c;

    // The trailing parity bit completes the frame but never enters shift_q.
    assign shift_en_c = ~last_c;
    assign word_c     = shift_q;
    assign perr_c     = (^shift_q) ^ bus.din;
`else
    assign shift_en_c = 1'b1;
    assign word_c     = shift_next_c;
`endif

    // LSB-first streams put the first received bit at dout[0].
    always_comb begin
        word_ord_c = word_c;
        if (ORDER == sipo_pkg::LSB_FIRST) begin
            for (int i = 0; i < int'(DATA_WIDTH); i++) begin
                word_ord_c[i] = word_c[DATA_WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (bus.flush) begin
            shift_q <= '0;
            bit_cnt <= '0;
        end else if (bus.din_valid) begin
            if (shift_en_c) begin
                shift_q <= shift_next_c;
            end
            bit_cnt <= last_c ? '0 : bit_cnt + CNT_W'(1);
        end
    end

    assign bus.shift_q = shift_q;
    assign bus.bit_cnt = bit_cnt;

    sipo_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .resetn     (resetn),
        .load       (complete_c),
        .load_data  (word_ord_c),
`ifdef SIPO_DESERIALIZER_PARITY_EN
        .load_perr  (perr_c),
        .parity_err (bus.parity_err),
`endif
        .ready      (bus.dout_ready),
        .dout       (bus.dout),
        .dout_valid (bus.dout_valid),
        .overflow   (bus.overflow)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: MSB-first and LSB-first instances on a shared serial stream,
// compared every cycle against a frame-level reference model.
module tb_sipo_deserializer;

    localparam int unsigned DW = 8;
`ifdef SIPO_DESERIALIZER_PARITY_EN
    localparam int unsigned FRAME = DW + 1;
`else
    localparam int unsigned FRAME = DW;
`endif
    localparam logic [63:0] MASK = (64'd1 << DW) - 64'd1;

    logic clk;
    logic resetn;
    logic din;
    logic din_valid;
    logic flush;
    logic dout_ready;

    int errors;
    int checks;

    // Reference state
    bit          m_bits[$];
    logic [63:0] m_shift;
    logic [63:0] m_dout[2];
    bit          m_valid;
    bit          m_ovf;
    bit          m_perr;

    sipo_if #(.DATA_WIDTH(DW)) bus0 ();
    sipo_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.din        = din;
    assign bus0.din_valid  = din_valid;
    assign bus0.flush      = flush;
    assign bus0.dout_ready = dout_ready;
    assign bus1.din        = din;
    assign bus1.din_valid  = din_valid;
    assign bus1.flush      = flush;
    assign bus1.dout_ready = dout_ready;

    sipo_deserializer #(.DATA_WIDTH(DW), .LSB_FIRST(0)) u_dut_msb (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    sipo_deserializer #(.DATA_WIDTH(DW), .LSB_FIRST(1)) u_dut_lsb (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: collect bits, assemble a word once a full frame has arrived.
    task automatic model_edge(input bit d, input bit dv, input bit fl, input bit rdy, input bit rst);
        bit          done;
        logic [63:0] wm;
        logic [63:0] wl;
        bit          pe;
        done = 1'b0;
        wm   = '0;
        wl   = '0;
        pe   = 1'b0;
        if (!rst) begin
            m_bits.delete();
            m_shift = '0;
            m_dout[0] = '0;
            m_dout[1] = '0;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_perr  = 1'b0;
            return;
        end
        if (fl) begin
            m_bits.delete();
            m_shift = '0;
        end else if (dv) begin
            if (m_bits.size() < DW) m_shift = ((m_shift << 1) | 64'(d)) & MASK;
            m_bits.push_back(d);
            if (m_bits.size() == FRAME) begin
                done = 1'b1;
                for (int i = 0; i < int'(FRAME); i++) pe ^= m_bits[i];
                for (int i = 0; i < int'(DW); i++) begin
                    wm |= 64'(m_bits[i]) << (DW - 1 - i);
                    wl |= 64'(m_bits[i]) << i;
                end
                m_bits.delete();
            end
        end
        if (done) begin
            if (!m_valid || rdy) begin
                m_valid   = 1'b1;
                m_dout[0] = wm;
                m_dout[1] = wl;
                m_perr    = pe;
            end else begin
                m_ovf = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all();
        check_eq("shift_q",    64'(bus0.shift_q),    m_shift);
        check_eq("bit_cnt",    64'(bus0.bit_cnt),    64'(m_bits.size()));
        check_eq("dout_valid", 64'(bus0.dout_valid), 64'(m_valid));
        check_eq("overflow",   64'(bus0.overflow),   64'(m_ovf));
        check_eq("dout_msb",   64'(bus0.dout),       m_dout[0]);
        check_eq("dout_lsb",   64'(bus1.dout),       m_dout[1]);
`ifdef SIPO_DESERIALIZER_PARITY_EN
        check_eq("parity_err", 64'(bus0.parity_err), 64'(m_perr));
`endif
    endtask

    task automatic cycle(input bit d, input bit dv, input bit fl, input bit rdy, input bit rst);
        din        = d;
        din_valid  = dv;
        flush      = fl;
        dout_ready = rdy;
        resetn     = rst;
        @(posedge clk);
        model_edge(d, dv, fl, rdy, rst);
        #1;
        compare_all();
    endtask

    // Sends a word MSB-first; the parity build appends even parity, optionally inverted.
    task automatic send_word(input logic [7:0] w, input bit rdy, input bit pflip);
        for (int i = int'(DW) - 1; i >= 0; i--) cycle(w[i], 1'b1, 1'b0, rdy, 1'b1);
`ifdef SIPO_DESERIALIZER_PARITY_EN
        cycle((^w) ^ pflip, 1'b1, 1'b0, rdy, 1'b1);
`else
        if (pflip) cycle(1'b0, 1'b0, 1'b0, rdy, 1'b1);
`endif
    endtask

    initial begin
        logic [7:0] w;
        errors     = 0;
        checks     = 0;
        din        = 1'b0;
        din_valid  = 1'b0;
        flush      = 1'b0;
        dout_ready = 1'b0;
        resetn     = 1'b0;
        m_shift    = '0;
        m_dout[0]  = '0;
        m_dout[1]  = '0;
        m_valid    = 1'b0;
        m_ovf      = 1'b0;
        m_perr     = 1'b0;

        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("rst_dout_valid", 64'(bus0.dout_valid), 64'd0);
        check_eq("rst_bit_cnt",    64'(bus0.bit_cnt),    64'd0);

        // Basic word, both bit orders
        send_word(8'hB2, 1'b1, 1'b0);
        check_eq("b2_dout",       64'(bus0.dout),       64'hB2);
        check_eq("b2_dout_valid", 64'(bus0.dout_valid), 64'd1);
        check_eq("b2_bit_cnt",    64'(bus0.bit_cnt),    64'd0);
        check_eq("b2_lsb_dout",   64'(bus1.dout),       64'h4D);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("b2_drained",    64'(bus0.dout_valid), 64'd0);

        // Backpressure: second word dropped
        send_word(8'hB2, 1'b0, 1'b0);
        send_word(8'h11, 1'b0, 1'b0);
        check_eq("ovf_dout_held", 64'(bus0.dout),     64'hB2);
        check_eq("ovf_set",       64'(bus0.overflow), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        check_eq("ovf_drain_valid", 64'(bus0.dout_valid), 64'd0);
        check_eq("ovf_sticky",      64'(bus0.overflow),   64'd1);

        // Flush mid-word, with a simultaneous valid bit
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        check_eq("flush_bit_cnt", 64'(bus0.bit_cnt), 64'd0);
        check_eq("flush_shift_q", 64'(bus0.shift_q), 64'd0);
        send_word(8'hA5, 1'b1, 1'b0);
        check_eq("flush_a5_dout", 64'(bus0.dout), 64'hA5);

        // Reset mid-word
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(8'h3C, 1'b1, 1'b0);
        check_eq("rst_3c_dout", 64'(bus0.dout),     64'h3C);
        check_eq("rst_3c_ovf",  64'(bus0.overflow), 64'd0);

`ifdef SIPO_DESERIALIZER_PARITY_EN
        send_word(8'hB2, 1'b1, 1'b0);
        check_eq("par_ok",  64'(bus0.parity_err), 64'd0);
        send_word(8'hB2, 1'b1, 1'b1);
        check_eq("par_bad", 64'(bus0.parity_err), 64'd1);
`endif

        // Randomized traffic, including parity-bit flips
        for (int n = 0; n < 40; n++) begin
            w = 8'($urandom);
            send_word(w, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0);
        end
        for (int n = 0; n < 600; n++) begin
            cycle(1'($urandom), $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 149) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
